// File: rtl/dmux_dispatcher.sv
// dmux_dispatcher: single-entry dispatcher steering items to LANES lanes.
// Ports: in_* producer side, out_* lane side, xfer_cnt/reroute_cnt stats.
module dmux_dispatcher #(
  parameter int WIDTH       = 16,
  parameter int LANES       = 4,
  parameter int SELW        = $clog2(LANES),
  parameter int STALL_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SELW-1:0]  in_sel,
  input  logic             mode,
  output logic [LANES-1:0] out_valid,
  input  logic [LANES-1:0] out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  out_lane,
  output logic [15:0]      xfer_cnt,
  output logic [7:0]       reroute_cnt
);

  localparam int CW =
    (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [CW-1:0] STALL_MAX =
    CW'((STALL_LIMIT > 0) ? STALL_LIMIT - 1 : 0);
  localparam logic RR_EN = (STALL_LIMIT != 0);

  typedef enum logic {
    EMPTY,
    FULL
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0] lane_q;
  logic [SELW-1:0] rr_ptr;
  logic            mode_q;
  logic [CW-1:0]   stall_q;
  logic            full;
  logic            xfer;
  logic            cap;
  logic            reroute;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    full      = (state_q == FULL);
    xfer      = full & out_ready[lane_q];
    in_ready  = ~full | xfer;
    cap       = in_valid & in_ready;
    reroute   = full & mode_q & RR_EN &
                (stall_q == STALL_MAX) & ~xfer;
    out_valid = '0;
    if (full) out_valid[lane_q] = 1'b1;
    if (cap)       state_d = FULL;
    else if (xfer) state_d = EMPTY;
  end

  assign out_data = data_q;
  assign out_lane = lane_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      lane_q      <= '0;
      mode_q      <= 1'b0;
      rr_ptr      <= '0;
      stall_q     <= '0;
      xfer_cnt    <= '0;
      reroute_cnt <= '0;
    end else begin
      if (xfer) xfer_cnt <= xfer_cnt + 16'd1;
      if (cap) begin
        data_q <= in_data;
        lane_q <= mode ? rr_ptr : in_sel;
        mode_q <= mode;
        if (mode) rr_ptr <= rr_ptr + SELW'(1);
      end else if (reroute) begin
        lane_q <= lane_q + SELW'(1);
      end
      if (reroute && reroute_cnt != 8'hFF)
        reroute_cnt <= reroute_cnt + 8'd1;
      if (cap || xfer || reroute)
        stall_q <= '0;
      else if (full)
        stall_q <= stall_q + CW'(1);
    end
  end

endmodule

// File: doc/dmux_dispatcher.md
# dmux_dispatcher

Sequencing controller for the demultiplexer datapath. It accepts one input stream and holds each item in a single-entry register. Each item is steered to one of LANES output lanes, either addressed by the producer or assigned round-robin. It sits between a single producer and the DMux fan-out, gating per-lane valid and holding data until the selected consumer accepts. Stall-based rerouting and transfer counting support system bring-up.

## Interface
- WIDTH, 16, data width in bits
- LANES, 4, number of output lanes; power of two, 2..8
- SELW, $clog2(LANES), lane-index width (derived, not overridden)
- STALL_LIMIT, 8, cycles a held item may wait before reroute in round-robin mode; 0 disables reroute

- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  producer has an item
- in_ready  out  1  dispatcher accepts the item this cycle
- in_data  in  WIDTH  item payload
- in_sel  in  SELW  target lane, used when mode=0
- mode  in  1  0 = addressed (in_sel), 1 = round-robin; sampled at capture
- out_valid  out  LANES  one-hot; bit k set while the held item targets lane k
- out_ready  in  LANES  per-lane consumer ready
- out_data  out  WIDTH  held payload, shared by all lanes
- out_lane  out  SELW  index of current target lane
- xfer_cnt  out  16  completed output transfers, wraps at 2^16
- reroute_cnt  out  8  stall-triggered reroutes, saturates at 255

## Operation
- States:
  - EMPTY: no item held.
  - FULL: item held in data_q, targeting lane_q; mode_q is the mode latched at capture.
- Capture: in_valid & in_ready.
  - data_q <= in_data.
  - lane_q <= mode ? rr_ptr : in_sel.
  - mode_q <= mode.
  - Enter or stay in FULL.
- rr_ptr advances by 1 mod LANES on every capture with mode=1. It is unchanged on captures with mode=0 and on reroutes.
- Transfer: FULL & out_ready[lane_q].
  - xfer_cnt increments.
  - State goes to EMPTY unless a capture occurs in the same cycle.
- in_ready = EMPTY | transfer. This gives a combinational path from out_ready, so the block sustains one item per cycle.
- out_valid = FULL ? (1 << lane_q) : 0.
  - out_valid never depends on out_ready.
  - out_data and out_lane stay stable while FULL and untransferred.
- Stall counter:
  - Clears on capture, transfer and reroute.
  - Otherwise increments each FULL cycle.
- Reroute: only when mode_q=1, STALL_LIMIT≠0, stall counter = STALL_LIMIT-1 and no transfer this cycle.
  - lane_q <= lane_q+1 mod LANES.
  - reroute_cnt increments (saturating).
  - The held item and data are unchanged.
- mode_q=0 items wait indefinitely on their addressed lane.
- Priority within one cycle: transfer over reroute. A capture together with a transfer loads the new item; its lane is computed from rr_ptr before the increment.

## Timing
- Reset values (asynchronous, while rst_n=0): state EMPTY, out_valid=0, out_data=0, out_lane=0, rr_ptr=0, stall counter=0, xfer_cnt=0, reroute_cnt=0, in_ready=1.
- Capture-to-out_valid latency: 1 cycle. out_valid is asserted the cycle after the capture edge.
- Back-to-back items: with the target lane ready every cycle, one transfer per cycle and no bubbles.
- Reroute takes effect on the edge ending the STALL_LIMIT-th consecutive stalled FULL cycle. The new out_valid bit appears on the next cycle.
- Wrap-around:
  - rr_ptr, lane_q wrap LANES-1 -> 0.
  - xfer_cnt wraps 0xFFFF -> 0x0000.
  - reroute_cnt holds at 0xFF.
- Reset asserted mid-transfer drops the held item. No out_valid is seen after rst_n falls.
- Changing mode while FULL has no effect on the held item.

## Test plan
- Reset: drive rst_n=0 mid-FULL -> out_valid=0, in_ready=1, xfer_cnt=0 immediately, before any clock edge.
- Addressed:
  - Stimulus: mode=0, in_data=0x00AA, in_sel=2, out_ready=4'b0100.
  - Response: cycle after capture out_valid=4'b0100, out_data=0x00AA; next cycle EMPTY, xfer_cnt=1.
- Round-robin streaming:
  - Stimulus: mode=1, 8 consecutive items 0x0001..0x0008, all out_ready=1.
  - Response: out_lane sequence 0,1,2,3,0,1,2,3; one transfer per cycle; xfer_cnt=8; in_ready never deasserted.
- Reroute:
  - Stimulus: mode=1, STALL_LIMIT=8, out_ready=4'b1110, item captured to lane 0.
  - Response: out_valid=4'b0001 for 8 cycles, then 4'b0010 and the transfer completes; reroute_cnt=1, rr_ptr=1.
- Addressed stall:
  - Stimulus: mode=0, in_sel=3, out_ready=0 for 50 cycles.
  - Response: out_valid=4'b1000 throughout, reroute_cnt=0, in_ready=0; transfer on the first cycle out_ready[3]=1.
- Counter wrap: preset via 65536 transfers -> xfer_cnt returns to 0x0000.
